// File: rtl/porta_ctrl_scan_seq.sv
// rtl/porta_ctrl_scan_seq.sv - hand-controller port select sequencer, debouncer and snapshot reader
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   mode_kp_wr         1-cycle strobe selecting keypad mode
//   mode_js_wr         1-cycle strobe selecting joystick mode (wins over mode_kp_wr)
//   rd_req, rd_sel     1-cycle read request and controller select (0=ctrl1, 1=ctrl2)
//   c1_in, c2_in       raw active-low controller pins, asynchronous to clk
//   kp_sel_n, js_sel_n active-low common selects, exactly one low at a time
//   rd_data, rd_ack    formatted snapshot byte, valid for the single ack cycle
//   chg_p              1-cycle pulse after any snapshot bit commits
//   scanning           high while inputs are being debounced into snapshots
module porta_ctrl_scan_seq #(
  parameter int SETTLE_CYCLES = 64,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_kp_wr,
  input  logic       mode_js_wr,
  input  logic       rd_req,
  input  logic       rd_sel,
  input  logic [5:0] c1_in,
  input  logic [5:0] c2_in,
  output logic       kp_sel_n,
  output logic       js_sel_n,
  output logic [7:0] rd_data,
  output logic       rd_ack,
  output logic       chg_p,
  output logic       scanning
);

  typedef enum logic {ST_SETTLE, ST_SCAN} state_t;

  localparam logic MODE_JS = 1'b0;
  localparam logic MODE_KP = 1'b1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CNT - 1);

  state_t                        state;
  logic                          mode;
  logic [CNT_W-1:0]              settle_cnt;
  logic [1:0][5:0]               sync1;
  logic [1:0][5:0]               sync2;
  // snap[mode][ctrl]
  logic [1:0][1:0][5:0]          snap;
  // db_cnt[ctrl][bit], shared by both modes because a mode change clears it
  logic [1:0][5:0][CNT_W-1:0]    db_cnt;

  logic                          new_mode;
  logic                          want_change;
  logic [1:0][5:0][CNT_W-1:0]    db_cnt_nxt;
  logic [1:0][5:0]               snap_cur_nxt;
  logic                          any_commit;

  function automatic logic [7:0] fmt(input logic [5:0] v);
    fmt = {1'b0, v[5], v[4], 1'b1, v[3:0]};
  endfunction

  // JS is checked first so it wins when both strobes arrive together;
  // a strobe for the mode already selected leaves new_mode == mode.
  always_comb begin
    new_mode = mode;
    if (mode_js_wr)
      new_mode = MODE_JS;
    else if (mode_kp_wr)
      new_mode = MODE_KP;
    want_change = (new_mode != mode);
  end

  // Per-bit debounce against the current mode's snapshot. A bit commits on
  // the DEBOUNCE_CNT-th consecutive synchronised sample that disagrees.
  always_comb begin
    db_cnt_nxt   = db_cnt;
    snap_cur_nxt = snap[mode];
    any_commit   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int b = 0; b < 6; b++) begin
        if (sync2[c][b] == snap[mode][c][b]) begin
          db_cnt_nxt[c][b] = '0;
        end else if (db_cnt[c][b] >= DB_LAST) begin
          snap_cur_nxt[c][b] = sync2[c][b];
          db_cnt_nxt[c][b]   = '0;
          any_commit         = 1'b1;
        end else begin
          db_cnt_nxt[c][b] = db_cnt[c][b] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SETTLE;
      mode       <= MODE_JS;
      js_sel_n   <= 1'b0;
      kp_sel_n   <= 1'b1;
      settle_cnt <= '0;
      db_cnt     <= '0;
      sync1      <= {2{6'h3F}};
      sync2      <= {2{6'h3F}};
      snap       <= {4{6'h3F}};
      rd_data    <= 8'h00;
      rd_ack     <= 1'b0;
      chg_p      <= 1'b0;
      scanning   <= 1'b0;
    end else begin
      sync1 <= {c2_in, c1_in};
      sync2 <= sync1;

      // Reads use the registered snapshot, so a commit on the same edge is
      // not visible until the following read.
      rd_ack  <= rd_req;
      rd_data <= rd_req ? fmt(snap[mode][rd_sel]) : 8'h00;

      chg_p <= 1'b0;

      if (want_change) begin
        mode       <= new_mode;
        js_sel_n   <= (new_mode == MODE_KP);
        kp_sel_n   <= (new_mode == MODE_JS);
        settle_cnt <= '0;
        db_cnt     <= '0;
        state      <= ST_SETTLE;
        scanning   <= 1'b0;
      end else if (state == ST_SETTLE) begin
        if (settle_cnt >= SETTLE_LAST) begin
          state    <= ST_SCAN;
          scanning <= 1'b1;
        end else begin
          settle_cnt <= settle_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt     <= db_cnt_nxt;
        snap[mode] <= snap_cur_nxt;
        chg_p      <= any_commit;
      end
    end
  end

endmodule

// File: tb/tb_porta_ctrl_scan_seq.sv
// tb/tb_porta_ctrl_scan_seq.sv - directed table and sequence bench for porta_ctrl_scan_seq
module tb_porta_ctrl_scan_seq;

  logic       clk;
  logic       rst;
  logic       mode_kp_wr;
  logic       mode_js_wr;
  logic       rd_req;
  logic       rd_sel;
  logic [5:0] c1_in;
  logic [5:0] c2_in;
  logic       kp_sel_n;
  logic       js_sel_n;
  logic [7:0] rd_data;
  logic       rd_ack;
  logic       chg_p;
  logic       scanning;

  int passed;
  int total;

  typedef struct {
    logic [5:0] c1;
    logic [5:0] c2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs [6];

  porta_ctrl_scan_seq #(
    .SETTLE_CYCLES(8),
    .DEBOUNCE_CNT (3),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_kp_wr(mode_kp_wr),
    .mode_js_wr(mode_js_wr),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .c1_in     (c1_in),
    .c2_in     (c2_in),
    .kp_sel_n  (kp_sel_n),
    .js_sel_n  (js_sel_n),
    .rd_data   (rd_data),
    .rd_ack    (rd_ack),
    .chg_p     (chg_p),
    .scanning  (scanning)
  );

  initial clk = 1'b0;
  always #140 clk = ~clk;

  initial begin
    #(280 * 50000);
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_fmt(input logic [5:0] v);
    exp_fmt = {1'b0, v[5], v[4], 1'b1, v[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input string name, input logic sel, input logic [7:0] exp);
    rd_req = 1'b1;
    rd_sel = sel;
    step();
    rd_req = 1'b0;
    chk({name, "_ack"}, rd_ack, 1'b1);
    chk({name, "_data"}, rd_data, exp);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_js_sel_n"}, js_sel_n, 1'b0);
    chk({name, "_kp_sel_n"}, kp_sel_n, 1'b1);
    chk({name, "_rd_data"},  rd_data,  8'h00);
    chk({name, "_rd_ack"},   rd_ack,   1'b0);
    chk({name, "_chg_p"},    chg_p,    1'b0);
    chk({name, "_scanning"}, scanning, 1'b0);
  endtask

  initial begin
    passed = 0;
    total  = 0;

    vecs[0] = '{c1: 6'h00, c2: 6'h3F, exp1: 8'h10, exp2: 8'h7F};
    vecs[1] = '{c1: 6'h15, c2: 6'h2A, exp1: 8'h35, exp2: 8'h5A};
    vecs[2] = '{c1: 6'h30, c2: 6'h0F, exp1: 8'h70, exp2: 8'h1F};
    vecs[3] = '{c1: 6'h1F, c2: 6'h20, exp1: 8'h3F, exp2: 8'h50};
    vecs[4] = '{c1: 6'h3F, c2: 6'h3E, exp1: 8'h7F, exp2: 8'h7E};
    vecs[5] = '{c1: 6'h3F, c2: 6'h3F, exp1: 8'h7F, exp2: 8'h7F};

    rst        = 1'b1;
    mode_kp_wr = 1'b0;
    mode_js_wr = 1'b0;
    rd_req     = 1'b0;
    rd_sel     = 1'b0;
    c1_in      = 6'h3F;
    c2_in      = 6'h3F;

    // 1. reset, release, settle length, first read
    step(2);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    step(7);
    chk("settle_edge7_scanning", scanning, 1'b0);
    step();
    chk("settle_edge8_scanning", scanning, 1'b1);
    do_read("t1_read", 1'b0, 8'h7F);
    step();
    chk("t1_ack_drop", rd_ack, 1'b0);
    chk("t1_data_drop", rd_data, 8'h00);

    // 2. commit timing, read colliding with commit, glitch rejection
    c1_in = 6'h3E;
    step(4);
    chk("t2_no_commit_edge4", chg_p, 1'b0);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    step();
    rd_req = 1'b0;
    chk("t2_commit_edge5", chg_p, 1'b1);
    chk("t2_collide_read_pre", rd_data, 8'h7F);
    step();
    chk("t2_chg_single", chg_p, 1'b0);
    do_read("t2_read_after", 1'b0, 8'h7E);
    c1_in = 6'h3C;
    step(2);
    c1_in = 6'h3E;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (chg_p) pulses++;
      end
      chk("t2_glitch_no_chg", pulses, 0);
    end
    do_read("t2_glitch_read", 1'b0, 8'h7E);

    // 3. switch to KP, read during settle, return to JS
    mode_kp_wr = 1'b1;
    step();
    mode_kp_wr = 1'b0;
    chk("t3_kp_sel_n", kp_sel_n, 1'b0);
    chk("t3_js_sel_n", js_sel_n, 1'b1);
    chk("t3_scanning_off", scanning, 1'b0);
    do_read("t3_kp_settle_read", 1'b0, 8'h7F);
    step(6);
    chk("t3_kp_settle_edge7", scanning, 1'b0);
    step();
    chk("t3_kp_settle_edge8", scanning, 1'b1);
    mode_js_wr = 1'b1;
    step();
    mode_js_wr = 1'b0;
    chk("t3_back_js_sel_n", js_sel_n, 1'b0);
    do_read("t3_js_read", 1'b0, 8'h7E);
    step(10);

    // 4. simultaneous strobes while in JS, repeated JS strobe
    chk("t4_pre_scanning", scanning, 1'b1);
    mode_kp_wr = 1'b1;
    mode_js_wr = 1'b1;
    step();
    mode_kp_wr = 1'b0;
    chk("t4_both_js_sel_n", js_sel_n, 1'b0);
    chk("t4_both_kp_sel_n", kp_sel_n, 1'b1);
    chk("t4_both_no_restart", scanning, 1'b1);
    step();
    mode_js_wr = 1'b0;
    chk("t4_repeat_js_no_restart", scanning, 1'b1);

    // 5. KP-mode commit on ctrl2, JS ctrl2 frozen
    mode_kp_wr = 1'b1;
    c2_in = 6'h1F;
    step();
    mode_kp_wr = 1'b0;
    step(16);
    do_read("t5_kp_c2", 1'b1, 8'h3F);
    mode_js_wr = 1'b1;
    step();
    mode_js_wr = 1'b0;
    do_read("t5_js_c2_frozen", 1'b1, 8'h7F);
    c2_in = 6'h3F;
    step(10);

    // 6a. reset mid-debounce with a read in flight
    c1_in = 6'h3C;
    step(2);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    step();
    rd_req = 1'b0;
    chk("t6_pre_rst_ack", rd_ack, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst_debounce");
    c1_in = 6'h3F;
    #1;
    rst = 1'b0;
    step(8);
    chk("t6_resettle", scanning, 1'b1);
    do_read("t6_snap_c1", 1'b0, 8'h7F);

    // 6b. reset mid-settle in KP mode
    mode_kp_wr = 1'b1;
    step();
    mode_kp_wr = 1'b0;
    step(3);
    chk("t6_mid_settle_kp", kp_sel_n, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst_settle");
    #1;
    rst = 1'b0;
    step(8);
    do_read("t6_kp_gone_c2", 1'b1, 8'h7F);

    // directed vector table in JS scan
    foreach (vecs[i]) begin
      c1_in = vecs[i].c1;
      c2_in = vecs[i].c2;
      step(10);
      do_read($sformatf("vec%0d_c1", i), 1'b0, vecs[i].exp1);
      do_read($sformatf("vec%0d_c2", i), 1'b1, vecs[i].exp2);
    end

    // back-to-back reads
    rd_req = 1'b1;
    rd_sel = 1'b0;
    c1_in  = 6'h2A;
    c2_in  = 6'h15;
    step(10);
    chk("b2b_ack0", rd_ack, 1'b1);
    rd_sel = 1'b1;
    step();
    chk("b2b_ack1", rd_ack, 1'b1);
    chk("b2b_data1", rd_data, 8'h35);
    rd_sel = 1'b0;
    step();
    rd_req = 1'b0;
    chk("b2b_ack2", rd_ack, 1'b1);
    chk("b2b_data2", rd_data, 8'h5A);

    // full sweep
    for (int v = 0; v < 64; v++) begin
      c1_in = 6'(v);
      c2_in = 6'(63 - v);
      step(12);
      do_read($sformatf("sweep%0d_c1", v), 1'b0, exp_fmt(6'(v)));
      do_read($sformatf("sweep%0d_c2", v), 1'b1, exp_fmt(6'(63 - v)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
